// File: rtl/button_pkg.sv
// Shared definitions for the button gesture decoder.
// Contents:
//   state_t  - gesture FSM states (IDLE, PRESS1, GAP, PRESS2, LONG)
//   EVT_*    - event codes presented on evt_code
package button_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    GAP    = 3'd2,
    PRESS2 = 3'd3,
    LONG   = 3'd4
  } state_t;

  localparam logic [1:0] EVT_NONE   = 2'b00;
  localparam logic [1:0] EVT_CLICK  = 2'b01;
  localparam logic [1:0] EVT_DOUBLE = 2'b10;
  localparam logic [1:0] EVT_LONG   = 2'b11;

endpackage

// File: rtl/button_gesture_decoder_if.sv
// Event channel between the gesture decoder and its consumer.
// Signals:
//   evt_valid  producer -> consumer  event slot occupied
//   evt_code   producer -> consumer  01 click, 10 double, 11 long
//   evt_drop   producer -> consumer  sticky: an event was lost (slot full)
//   evt_ready  consumer -> producer  consumer takes the slot this cycle
interface button_gesture_decoder_if;
  logic       evt_valid;
  logic [1:0] evt_code;
  logic       evt_drop;
  logic       evt_ready;

  modport master (output evt_valid, output evt_code, output evt_drop, input evt_ready);
  modport slave  (input evt_valid, input evt_code, input evt_drop, output evt_ready);
endinterface

// File: rtl/event_slot.sv
// One-entry valid/ready holding register for gesture events.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   emit        load emit_code this edge (if the slot can take it)
//   emit_code   event code to load
//   ready       consumer accepts the slot this cycle
//   valid       slot occupied (registered)
//   code        held event code (registered)
//   drop        sticky lost-event flag, cleared only by reset
module event_slot (
  input  logic       clk,
  input  logic       rst,
  input  logic       emit,
  input  logic [1:0] emit_code,
  input  logic       ready,
  output logic       valid,
  output logic [1:0] code,
  output logic       drop
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      code  <= 2'b00;
      drop  <= 1'b0;
    end else if (emit) begin
      if (valid && !ready) begin
        // Slot still owned by the consumer: keep the old event, flag the loss.
        drop <= 1'b1;
      end else begin
        // Empty, or being emptied on this very edge: replace seamlessly.
        valid <= 1'b1;
        code  <= emit_code;
      end
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/button_gesture_decoder.sv
// Classifies a debounced button level into click / double-click / long-press
// events, presented through a one-entry valid/ready slot.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   btn_level   debounced level, 1 = pressed (synchronous to clk)
//   held        btn_level delayed by one cycle
//   evt         event channel (valid, code, drop out; ready in)
module button_gesture_decoder
  import button_pkg::*;
#(
  parameter int LONG_CYCLES = 50_000_000,
  parameter int GAP_CYCLES  = 15_000_000,
  parameter int CNT_W       = 26
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      btn_level,
  output logic                      held,
  button_gesture_decoder_if.master  evt
);

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             prev_reg;
  logic             held_reg;

  logic       rise;
  logic       fall;
  logic       emit_long;
  logic       emit_click;
  logic       emit_double;
  logic       emit;
  logic [1:0] emit_code;

  assign rise = btn_level & ~prev_reg;
  assign fall = ~btn_level & prev_reg;

  // Release is checked before long detection; a rise in GAP beats the timeout.
  assign emit_long   = (state_reg == PRESS1) && btn_level && (cnt_reg == LONG_LAST);
  assign emit_click  = (state_reg == GAP) && !rise && (cnt_reg == GAP_LAST);
  assign emit_double = (state_reg == PRESS2) && fall;

  always_comb begin
    emit      = emit_long | emit_click | emit_double;
    emit_code = EVT_NONE;
    if (emit_long)   emit_code = EVT_LONG;
    if (emit_click)  emit_code = EVT_CLICK;
    if (emit_double) emit_code = EVT_DOUBLE;
  end

  // prev resets to 1 so a button held through reset must be released first.
  // The counter only advances in PRESS1 and GAP, the states with a timeout;
  // elsewhere it is parked at zero so it can never wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      prev_reg  <= 1'b1;
      held_reg  <= 1'b0;
    end else begin
      prev_reg <= btn_level;
      held_reg <= btn_level;
      cnt_reg  <= '0;
      case (state_reg)
        IDLE: begin
          if (rise) state_reg <= PRESS1;
        end
        PRESS1: begin
          if (!btn_level)     state_reg <= GAP;
          else if (emit_long) state_reg <= LONG;
          else                cnt_reg   <= cnt_reg + 1'b1;
        end
        GAP: begin
          if (rise)            state_reg <= PRESS2;
          else if (emit_click) state_reg <= IDLE;
          else                 cnt_reg   <= cnt_reg + 1'b1;
        end
        PRESS2: begin
          if (fall) state_reg <= IDLE;
        end
        LONG: begin
          if (fall) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign held = held_reg;

  event_slot u_slot (
    .clk       (clk),
    .rst       (rst),
    .emit      (emit),
    .emit_code (emit_code),
    .ready     (evt.evt_ready),
    .valid     (evt.evt_valid),
    .code      (evt.evt_code),
    .drop      (evt.evt_drop)
  );

endmodule

// File: tb/tb_button_gesture_decoder.sv
// Scoreboard bench for button_gesture_decoder (LONG_CYCLES=20, GAP_CYCLES=8).
// The driver steps a timestamp-based gesture model on every active edge and
// queues each event that enters the slot; a monitor on the falling edge pops
// and compares whenever the consumer takes an event.
module tb_button_gesture_decoder;

  localparam int LONG = 20;
  localparam int GAP  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_level = 1'b0;
  logic held;

  button_gesture_decoder_if evt ();

  button_gesture_decoder #(
    .LONG_CYCLES (LONG),
    .GAP_CYCLES  (GAP),
    .CNT_W       (5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_level (btn_level),
    .held      (held),
    .evt       (evt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] code;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  int   cyc    = 0;
  logic held_exp = 1'b0;

  // Gesture model: phase of the gesture plus the edge at which it began.
  typedef enum int {M_IDLE, M_DOWN1, M_UP1, M_DOWN2, M_HOLD} mphase_t;
  mphase_t m_phase = M_IDLE;
  int      t_mark  = 0;
  logic    m_prev  = 1'b1;
  logic    m_valid = 1'b0;
  logic    m_drop  = 1'b0;

  function automatic void chk(string name, int act, int req);
    n_vec++;
    if (act != req) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  function automatic void model_reset();
    m_phase  = M_IDLE;
    m_prev   = 1'b1;
    m_valid  = 1'b0;
    m_drop   = 1'b0;
    held_exp = 1'b0;
    q.delete();
  endfunction

  // One active edge: gesture rules from timestamps, then slot rules.
  task automatic step(input logic b, input logic r);
    logic       rise;
    logic       fall;
    logic       em;
    logic [1:0] code;
    exp_t       e;
    rise = b && !m_prev;
    fall = !b && m_prev;
    em   = 1'b0;
    code = 2'b00;
    case (m_phase)
      M_IDLE:  if (rise) begin m_phase = M_DOWN1; t_mark = cyc; end
      M_DOWN1: if (!b) begin m_phase = M_UP1; t_mark = cyc; end
               else if (cyc - t_mark == LONG) begin em = 1'b1; code = 2'b11; m_phase = M_HOLD; end
      M_UP1:   if (rise) m_phase = M_DOWN2;
               else if (cyc - t_mark == GAP) begin em = 1'b1; code = 2'b01; m_phase = M_IDLE; end
      M_DOWN2: if (fall) begin em = 1'b1; code = 2'b10; m_phase = M_IDLE; end
      M_HOLD:  if (fall) m_phase = M_IDLE;
      default: m_phase = M_IDLE;
    endcase
    if (em) begin
      if (m_valid && !r) m_drop = 1'b1;
      else begin
        m_valid = 1'b1;
        e.code = code;
        e.cyc  = cyc;
        q.push_back(e);
        $display("vector: cycle %0d event %0d queued", cyc, code);
      end
    end else if (m_valid && r) begin
      m_valid = 1'b0;
    end
    m_prev = b;
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    held_exp = rst ? 1'b0 : btn_level;
    if (!rst) step(btn_level, evt.evt_ready);
    #1;
  endtask

  task automatic seg(input logic level, input int n);
    btn_level = level;
    repeat (n) tick();
  endtask

  // Asynchronous assertion mid-cycle; outputs must clear without a clock edge.
  task automatic apply_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst_async_valid", int'(evt.evt_valid), 0);
    chk("rst_async_code", int'(evt.evt_code), 0);
    chk("rst_async_drop", int'(evt.evt_drop), 0);
    chk("rst_async_held", int'(held), 0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Monitor: per-cycle flag checks plus scoreboard pop on each handshake.
  initial begin
    logic vprev;
    logic hsprev;
    int   load_cyc;
    exp_t e;
    vprev = 1'b0;
    hsprev = 1'b0;
    load_cyc = 0;
    forever begin
      @(negedge clk);
      chk("held", int'(held), int'(held_exp));
      chk("evt_valid", int'(evt.evt_valid), int'(m_valid));
      chk("evt_drop", int'(evt.evt_drop), int'(m_drop));
      if (rst) begin
        vprev = 1'b0;
        hsprev = 1'b0;
      end else begin
        if (evt.evt_valid && (!vprev || hsprev)) load_cyc = cyc;
        if (evt.evt_valid && evt.evt_ready) begin
          chk("evt_queue_depth", (q.size() > 0) ? 1 : 0, 1);
          if (q.size() > 0) begin
            e = q.pop_front();
            chk("evt_code", int'(evt.evt_code), int'(e.code));
            chk("evt_edge", load_cyc, e.cyc);
          end
        end
        vprev  = evt.evt_valid;
        hsprev = evt.evt_valid && evt.evt_ready;
      end
    end
  end

  initial begin
    evt.evt_ready = 1'b1;
    btn_level = 1'b0;
    model_reset();
    tick();
    tick();
    chk("reset_valid", int'(evt.evt_valid), 0);
    chk("reset_code", int'(evt.evt_code), 0);
    chk("reset_drop", int'(evt.evt_drop), 0);
    rst = 1'b0;
    seg(0, 3);

    // Click, double, long.
    seg(1, 5);  seg(0, 20);
    seg(1, 4);  seg(0, 3);  seg(1, 4);  seg(0, 20);
    seg(1, 30); seg(0, 20);
    // Release on the terminal long count: still a click.
    seg(1, 20); seg(0, 20);
    // Second press lands exactly on the gap timeout: double.
    seg(1, 4);  seg(0, GAP); seg(1, 3); seg(0, 20);

    // Stalled consumer: long then click, the click is dropped.
    evt.evt_ready = 1'b0;
    seg(1, 25); seg(0, 3); seg(1, 3); seg(0, 12);
    chk("stall_code_kept", int'(evt.evt_code), 3);
    chk("stall_drop_set", int'(evt.evt_drop), 1);
    evt.evt_ready = 1'b1;
    seg(0, 2);
    chk("stall_cleared", int'(evt.evt_valid), 0);
    chk("stall_drop_sticky", int'(evt.evt_drop), 1);

    // Button held through reset: first hold ignored, later press normal.
    btn_level = 1'b1;
    apply_reset();
    seg(1, 30); seg(0, 5); seg(1, 5); seg(0, 20);

    // Reset in the middle of GAP: no click afterwards.
    seg(1, 5); seg(0, 3);
    apply_reset();
    seg(0, 20);

    // Randomized gestures with a wobbly consumer and occasional resets.
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 19) == 0) apply_reset();
      evt.evt_ready = ($urandom_range(0, 3) != 0);
      seg(logic'(i % 2 == 0), int'($urandom_range(1, 28)));
    end

    evt.evt_ready = 1'b1;
    seg(0, 40);
    chk("queue_drained", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
